binary_search_ctrl: RTL
=======================

BINARY_SEARCH_CTRL -- requirements
Module: binary_search_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the code driven into the FIR filter.
REQ-002 SHALL have parameter OUT_W, default 20, width of the FIR filter output and of the target.
REQ-003 SHALL have parameter SETTLE_CYC, default 16, number of cycles to wait for the FIR output to settle after each code change (range 1..255).
REQ-004 SHALL use one clock and an asynchronous, active-high reset: CLK_Filter  in  1  sole clock, rising edge; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have these further ports: start  in  1  search request; abort  in  1  cancel search; target  in  OUT_W  unsigned set-point; fir_out  in  OUT_W  unsigned FIR output_data; fir_in  out  DATA_W  code to FIR input_data; code  out  DATA_W  last completed result; busy  out  1  search in progress; done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement states IDLE, SET, SETTLE, COMPARE, DONE.
REQ-007 In IDLE with start=1 and abort=0: latch target into target_q, set trial=1000_0000b (MSB only), set bit index=DATA_W-1, go to SET.
REQ-008 SET: drive fir_in=trial, load the settle counter with SETTLE_CYC-1, go to SETTLE; SET lasts 1 cycle.
REQ-009 SETTLE: decrement the counter and go to COMPARE when it reads 0; SETTLE lasts exactly SETTLE_CYC cycles.
REQ-010 COMPARE: if fir_out > target_q (unsigned, strict), clear trial[idx]; on equality or less, keep the bit.
REQ-011 COMPARE with idx>0: set trial[idx-1], decrement idx, go to SET; with idx=0, go to DONE.
REQ-012 DONE: code<=trial, done=1 for that cycle only, go to IDLE; fir_in keeps driving the final code in IDLE.
REQ-013 Latency from the start-sampling edge to done=1 SHALL be DATA_W*(SETTLE_CYC+2)+1 cycles (145 at defaults).
REQ-014 busy SHALL be 1 in SET, SETTLE, COMPARE and DONE, and 0 in IDLE.
REQ-015 start while busy=1 SHALL be ignored; no queuing.
REQ-016 abort=1 in any non-IDLE state SHALL return to IDLE on the next edge: no done pulse, code unchanged, fir_in=0; abort has priority over start.
REQ-017 A target change during a search SHALL have no effect; only target_q is compared.
REQ-018 Boundaries: if the filtered output never exceeds the target, code=all-ones (0xFF); if it always exceeds, code=0x00; all outputs registered.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, fir_in=0, code=0, busy=0, done=0, trial=0, idx=0, counter=0, target_q=0, including mid-search.
REQ-020 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-021 Macro BSC_SAMPLE_AVG_EN: when defined, COMPARE SHALL take 2 cycles (sample fir_out, then compare (first+second)>>1 computed at OUT_W+1 bits against target_q), giving latency DATA_W*(SETTLE_CYC+3)+1 (153 at defaults).
REQ-022 Without BSC_SAMPLE_AVG_EN, the single-cycle compare of REQ-010 and the latency of REQ-013 SHALL apply, with no averaging logic present.

Verification (bench FIR model: fir_out = 1000*fir_in after a 4-cycle delay; defaults; macro undefined unless stated)
REQ-023 target=128000, pulse start -> done at cycle 145, code=0x80, fir_in=0x80, busy=0 the next cycle.
REQ-024 target=255000 -> code=0xFF; target=0 -> code=0x00; target=99999 -> code=0x63 (99).
REQ-025 Start a search with target=50000, pulse start again at cycle 20 with target=200000 -> single done at cycle 145, code=0x32.
REQ-026 abort at cycle 60 of a search -> busy=0 at cycle 61, no done, code retains the previous value, fir_in=0.
REQ-027 rst pulsed at cycle 70 of a search -> all outputs 0 asynchronously; a new start with target=128000 completes with code=0x80 at cycle 145.
REQ-028 BSC_SAMPLE_AVG_EN defined, target=128000 -> done at cycle 153, code=0x80.

Source files
------------

// File: rtl/binary_search_ctrl.sv
// Successive-approximation search for the FIR input code whose settled output best meets a target.
// Optional BSC_SAMPLE_AVG_EN: each comparison averages two consecutive fir_out samples.
module binary_search_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OUT_W      = 20,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic              CLK_Filter,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [OUT_W-1:0]  target,
  input  logic [OUT_W-1:0]  fir_out,
  output logic [DATA_W-1:0] fir_in,
  output logic [DATA_W-1:0] code,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      IDX_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [DATA_W-1:0] TRIAL_INIT = DATA_W'(1) << (DATA_W - 1);

`ifdef BSC_SAMPLE_AVG_EN
  typedef enum logic [2:0] {StIdle, StSet, StSettle, StCompare, StAverage, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StSet, StSettle, StCompare, StDone} state_e;
`endif

  state_e            r_state, w_state_nxt;
  logic [OUT_W-1:0]  r_target, w_target_nxt;
  logic [DATA_W-1:0] r_trial, w_trial_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_fir_in, w_fir_in_nxt;
  logic [DATA_W-1:0] r_code, w_code_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_resolve;
  logic              w_above;
  logic [IDX_W-1:0]  w_idx_dec;

  assign w_idx_dec = r_idx - IDX_ONE;

`ifdef BSC_SAMPLE_AVG_EN
  logic [OUT_W-1:0] r_sample, w_sample_nxt;
  logic [OUT_W:0]   w_sum;

  // One extra bit keeps the carry so the halved sum never wraps.
  assign w_sum   = {1'b0, r_sample} + {1'b0, fir_out};
  assign w_above = w_sum[OUT_W:1] > r_target;
`else
  assign w_above = fir_out > r_target;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_trial_nxt  = r_trial;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_fir_in_nxt = r_fir_in;
    w_code_nxt   = r_code;
    w_done_nxt   = 1'b0;
    w_resolve    = 1'b0;
`ifdef BSC_SAMPLE_AVG_EN
    w_sample_nxt = r_sample;
`endif

    if ((r_state != StIdle) && abort) begin
      w_state_nxt  = StIdle;
      w_fir_in_nxt = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start && !abort) begin
            w_target_nxt = target;
            w_trial_nxt  = TRIAL_INIT;
            w_idx_nxt    = IDX_TOP;
            w_state_nxt  = StSet;
          end
        end
        StSet: begin
          w_cnt_nxt   = SETTLE_LOAD;
          w_state_nxt = StSettle;
        end
        StSettle: begin
          if (r_cnt == '0) begin
            w_state_nxt = StCompare;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
`ifdef BSC_SAMPLE_AVG_EN
        StCompare: begin
          w_sample_nxt = fir_out;
          w_state_nxt  = StAverage;
        end
        StAverage: w_resolve = 1'b1;
`else
        StCompare: w_resolve = 1'b1;
`endif
        StDone: begin
          w_code_nxt  = r_trial;
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase

      if (w_resolve) begin
        if (w_above) begin
          w_trial_nxt[r_idx] = 1'b0;
        end
        if (r_idx != '0) begin
          w_trial_nxt[w_idx_dec] = 1'b1;
          w_idx_nxt              = w_idx_dec;
          w_state_nxt            = StSet;
        end else begin
          w_state_nxt = StDone;
        end
      end

      // fir_in follows each new trial, and holds the final code from DONE onwards.
      if ((w_state_nxt == StSet) || (w_state_nxt == StDone)) begin
        w_fir_in_nxt = w_trial_nxt;
      end
    end

    w_busy_nxt = (w_state_nxt != StIdle);
  end

  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_target <= '0;
      r_trial  <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_fir_in <= '0;
      r_code   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef BSC_SAMPLE_AVG_EN
      r_sample <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_trial  <= w_trial_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fir_in <= w_fir_in_nxt;
      r_code   <= w_code_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
`ifdef BSC_SAMPLE_AVG_EN
      r_sample <= w_sample_nxt;
`endif
    end
  end

  assign fir_in = r_fir_in;
  assign code   = r_code;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
